// File: rtl/psum_drain_deskew.sv
// South-edge psum collector: deskews the per-column psum stream, buffers aligned rows in a FIFO
// and drains them over valid/ready. Define DRAIN_QUANT_EN to quantise lanes on the FIFO write path.
module psum_drain_deskew #(
    parameter int COLS      = 8,
    parameter int PSUM_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ROWS      = 8,
    parameter int AF_MARGIN = 1,
    parameter int QSHIFT    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [COLS-1:0]            col_valid_in,
    input  logic [COLS*PSUM_W-1:0]     col_psum_in,
    input  logic                       flush,
    input  logic                       clear_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*PSUM_W-1:0]     out_data,
    output logic [$clog2(ROWS)-1:0]    out_row_idx,
    output logic                       out_last,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       skew_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(ROWS);
    localparam int ROW_W = COLS * PSUM_W;

`ifdef DRAIN_QUANT_EN
    // Saturating requantisation of one lane to an unsigned byte, zero-extended.
    function automatic logic [PSUM_W-1:0] quant_lane(input logic [PSUM_W-1:0] x);
        logic [PSUM_W-1:0] sh;
        sh = x >> QSHIFT;
        if (sh > {{(PSUM_W-8){1'b0}}, 8'hFF}) begin
            quant_lane = {{(PSUM_W-8){1'b0}}, 8'hFF};
        end else begin
            quant_lane = sh;
        end
    endfunction
`endif

    logic [COLS-1:0]             tail_v_s;
    logic [COLS-1:0][PSUM_W-1:0] tail_d_s;

    // Lane c is delayed COLS-1-c cycles so all lanes of a row meet at the tail together.
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign tail_v_s[c] = col_valid_in[c];
            assign tail_d_s[c] = col_psum_in[c*PSUM_W +: PSUM_W];
        end else begin : g_dly
            logic [D-1:0]             v_r;
            logic [D-1:0][PSUM_W-1:0] d_r;

            // Free-running delay line, cleared by reset or flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_r <= '0;
                    d_r <= '0;
                end else if (flush) begin
                    v_r <= '0;
                    d_r <= '0;
                end else begin
                    v_r[0] <= col_valid_in[c];
                    d_r[0] <= col_psum_in[c*PSUM_W +: PSUM_W];
                    for (int k = 1; k < D; k++) begin
                        v_r[k] <= v_r[k-1];
                        d_r[k] <= d_r[k-1];
                    end
                end
            end

            assign tail_v_s[c] = v_r[D-1];
            assign tail_d_s[c] = d_r[D-1];
        end
    end

    logic [ROW_W-1:0] wr_row_s;

    // Pack the aligned slot into a FIFO row, optionally quantised.
    always_comb begin
        wr_row_s = '0;
        for (int c = 0; c < COLS; c++) begin
`ifdef DRAIN_QUANT_EN
            wr_row_s[c*PSUM_W +: PSUM_W] = quant_lane(tail_d_s[c]);
`else
            wr_row_s[c*PSUM_W +: PSUM_W] = tail_d_s[c];
`endif
        end
    end

    logic [DEPTH-1:0][ROW_W-1:0] mem_r;
    logic [PTR_W-1:0]            wr_ptr_r;
    logic [PTR_W-1:0]            rd_ptr_r;
    logic [CNT_W-1:0]            count_r;
    logic [IDX_W-1:0]            idx_r;
    logic                        overflow_r;
    logic                        skew_err_r;

    logic push_req_s;
    logic skew_evt_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic ovf_evt_s;

    // Slot classification and FIFO control; flush suppresses every event.
    always_comb begin
        push_req_s = !flush && (&tail_v_s);
        skew_evt_s = !flush && (|tail_v_s) && !(&tail_v_s);
        full_s     = (count_r == CNT_W'(DEPTH));
        pop_s      = !flush && (count_r != {CNT_W{1'b0}}) && out_ready;
        push_s     = push_req_s && (!full_s || pop_s);
        ovf_evt_s  = push_req_s && full_s && !pop_s;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_row_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Row index within the output tile, advanced per pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if (flush) begin
            idx_r <= '0;
        end else if (pop_s) begin
            if (idx_r == IDX_W'(ROWS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // Sticky flags: a new event outranks a simultaneous clear; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            skew_err_r <= 1'b0;
        end else if (clear_err) begin
            overflow_r <= ovf_evt_s;
            skew_err_r <= skew_evt_s;
        end else begin
            overflow_r <= overflow_r | ovf_evt_s;
            skew_err_r <= skew_err_r | skew_evt_s;
        end
    end

    assign out_valid   = (count_r != {CNT_W{1'b0}});
    assign out_data    = mem_r[rd_ptr_r];
    assign out_row_idx = idx_r;
    assign out_last    = out_valid && (idx_r == IDX_W'(ROWS - 1));
    assign almost_full = (count_r >= CNT_W'(DEPTH - AF_MARGIN));
    assign overflow    = overflow_r;
    assign skew_err    = skew_err_r;

endmodule

// File: tb/tb_psum_drain_deskew.sv
// Bench for psum_drain_deskew (COLS=4, DEPTH=4, ROWS=8): directed vector table, directed sequences,
// and randomized traffic checked against a slot/queue level reference model.
module tb_psum_drain_deskew;
    localparam int COLS = 4;
    localparam int PW   = 32;
    localparam int DEP  = 4;
    localparam int NR   = 8;
    localparam int RW   = COLS * PW;
    localparam int HZ   = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [COLS-1:0] col_valid_in = '0;
    logic [RW-1:0]   col_psum_in = '0;
    logic            flush = 1'b0;
    logic            clear_err = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RW-1:0]   out_data;
    logic [2:0]      out_row_idx;
    logic            out_last;
    logic            almost_full;
    logic            overflow;
    logic            skew_err;

    psum_drain_deskew #(.COLS(COLS), .PSUM_W(PW), .DEPTH(DEP), .ROWS(NR), .AF_MARGIN(1), .QSHIFT(8)) dut (
        .clk(clk), .rst_n(rst_n), .col_valid_in(col_valid_in), .col_psum_in(col_psum_in),
        .flush(flush), .clear_err(clear_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row_idx(out_row_idx), .out_last(out_last),
        .almost_full(almost_full), .overflow(overflow), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: input schedule, aligned slots, FIFO queue, index and flags.
    bit            in_v [HZ][COLS];
    logic [PW-1:0] in_d [HZ][COLS];
    bit            sl_v [HZ][COLS];
    logic [PW-1:0] sl_d [HZ][COLS];
    logic [RW-1:0] mq[$];
    int            m_idx;
    bit            m_ovf;
    bit            m_skew;
    int            cyc = 0;

    function automatic logic [PW-1:0] model_lane(input logic [PW-1:0] x);
`ifdef DRAIN_QUANT_EN
        logic [PW-1:0] q;
        q = x >> 8;
        return (q > 32'd255) ? 32'd255 : q;
`else
        return x;
`endif
    endfunction

    task automatic clear_sched();
        for (int t = 0; t < HZ; t++)
            for (int c = 0; c < COLS; c++) begin
                in_v[t][c] = 1'b0; in_d[t][c] = '0;
                sl_v[t][c] = 1'b0; sl_d[t][c] = '0;
            end
    endtask

    // A row launched at cycle L drives lane c in cycle L+c (lane drop_lane withheld).
    task automatic launch_row(input int off, input logic [RW-1:0] row, input int drop_lane);
        for (int c = 0; c < COLS; c++) begin
            if (c != drop_lane) begin
                in_v[(cyc + off + c) % HZ][c] = 1'b1;
                in_d[(cyc + off + c) % HZ][c] = row[c*PW +: PW];
            end
        end
    endtask

    task automatic step(input logic rdy, input logic fl, input logic clr);
        logic [COLS-1:0] v;
        logic [RW-1:0]   d;
        logic [RW-1:0]   row;
        bit all_v, any_v, pop, full, ovf_evt, skew_evt;
        int t, s;
        t = cyc % HZ;
        for (int c = 0; c < COLS; c++) begin
            v[c] = in_v[t][c];
            d[c*PW +: PW] = in_d[t][c];
            in_v[t][c] = 1'b0;
        end
        col_valid_in = v; col_psum_in = d; out_ready = rdy; flush = fl; clear_err = clr;
        chk("out_valid", RW'(out_valid), RW'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", out_data, mq[0]);
        chk("out_row_idx", RW'(out_row_idx), RW'(m_idx));
        chk("out_last", RW'(out_last), RW'(mq.size() != 0 && m_idx == NR - 1));
        chk("almost_full", RW'(almost_full), RW'(mq.size() >= DEP - 1));
        chk("overflow", RW'(overflow), RW'(m_ovf));
        chk("skew_err", RW'(skew_err), RW'(m_skew));
        if (fl) begin
            clear_sched();
            mq.delete();
            m_idx = 0;
            if (clr) begin m_ovf = 0; m_skew = 0; end
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (v[c]) begin
                    sl_v[(cyc + COLS - 1 - c) % HZ][c] = 1'b1;
                    sl_d[(cyc + COLS - 1 - c) % HZ][c] = d[c*PW +: PW];
                end
            end
            all_v = 1; any_v = 0; row = '0;
            for (int c = 0; c < COLS; c++) begin
                all_v &= sl_v[t][c];
                any_v |= sl_v[t][c];
                row[c*PW +: PW] = model_lane(sl_d[t][c]);
                sl_v[t][c] = 1'b0;
            end
            skew_evt = any_v && !all_v;
            full = (mq.size() == DEP);
            pop = (mq.size() != 0) && rdy;
            ovf_evt = all_v && full && !pop;
            if (pop) begin
                void'(mq.pop_front());
                m_idx = (m_idx + 1) % NR;
            end
            if (all_v && !ovf_evt) mq.push_back(row);
            if (clr) begin m_ovf = ovf_evt; m_skew = skew_evt; end
            else begin m_ovf = m_ovf | ovf_evt; m_skew = m_skew | skew_evt; end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(rdy, 1'b0, 1'b0);
    endtask

    function automatic logic [RW-1:0] mk_row(input int base);
        logic [RW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*PW +: PW] = PW'(base + c);
        return r;
    endfunction

    typedef struct {
        logic [COLS-1:0] v;
        logic [RW-1:0]   d;
        logic            rdy;
        logic            exp_valid;
        logic [RW-1:0]   exp_data;
        logic [2:0]      exp_idx;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [RW-1:0] row_a;
        logic [RW-1:0] d;
        int lane;
        row_a = mk_row(100);
        for (int k = 0; k < 7; k++) begin
            tbl[k].v = (k < COLS) ? COLS'(1 << k) : '0;
            d = '0;
            if (k < COLS) d[k*PW +: PW] = PW'(100 + k);
            tbl[k].d = d;
            tbl[k].rdy = 1'b1;
            tbl[k].exp_valid = (k == COLS);
            tbl[k].exp_data = (k == COLS) ? row_a : '0;
            tbl[k].exp_idx = (k > COLS) ? 3'd1 : 3'd0;
        end
        clear_sched();
        mq.delete(); m_idx = 0; m_ovf = 0; m_skew = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single skewed row: valid exactly COLS cycles after lane 0, lanes realigned.
        for (int k = 0; k < 7; k++) begin
            col_valid_in = tbl[k].v; col_psum_in = tbl[k].d; out_ready = tbl[k].rdy;
            chk("tbl_valid", RW'(out_valid), RW'(tbl[k].exp_valid));
            chk("tbl_data", out_data, tbl[k].exp_data);
            chk("tbl_idx", RW'(out_row_idx), RW'(tbl[k].exp_idx));
            chk("tbl_last", RW'(out_last), RW'(1'b0));
            chk("tbl_af", RW'(almost_full), RW'(1'b0));
            chk("tbl_flags", RW'({overflow, skew_err}), RW'(2'b00));
            @(posedge clk); #1;
        end
        m_idx = 1;

        // Eight back-to-back rows: full tile index sweep with one out_last.
        for (int k = 0; k < 8; k++) launch_row(k, mk_row(200 + 16 * k), -1);
        run(16, 1'b1);
        chk("tile_wrap_idx", RW'(out_row_idx), RW'(m_idx));

        // Five rows into a stalled FIFO: fifth is dropped, first four drain in order.
        for (int k = 0; k < 5; k++) launch_row(k, mk_row(400 + 16 * k), -1);
        run(12, 1'b0);
        chk("fill_ovf", RW'(overflow), RW'(1'b1));
        chk("fill_af", RW'(almost_full), RW'(1'b1));
        run(8, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("clear_ovf", RW'(overflow), RW'(1'b0));

        // Push into a full FIFO while popping: no overflow, occupancy held.
        for (int k = 0; k < 4; k++) launch_row(k, mk_row(600 + 16 * k), -1);
        run(10, 1'b0);
        launch_row(0, mk_row(700), -1);
        run(3, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("full_pushpop_ovf", RW'(overflow), RW'(1'b0));
        chk("full_pushpop_af", RW'(almost_full), RW'(1'b1));
        run(8, 1'b1);

        // Lane 2 withheld: skew error, no push; clear, then a good row passes.
        launch_row(0, mk_row(800), 2);
        run(6, 1'b1);
        chk("skew_set", RW'(skew_err), RW'(1'b1));
        step(1'b1, 1'b0, 1'b1);
        chk("skew_clr", RW'(skew_err), RW'(1'b0));
        launch_row(0, mk_row(900), -1);
        run(8, 1'b1);

        // Flush with three rows buffered and one row mid-deskew.
        for (int k = 0; k < 3; k++) launch_row(k, mk_row(1000 + 16 * k), -1);
        run(8, 1'b0);
        launch_row(0, mk_row(1100), -1);
        run(2, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("flush_valid", RW'(out_valid), RW'(1'b0));
        chk("flush_idx", RW'(out_row_idx), RW'(3'd0));
        run(8, 1'b1);

        // Randomized traffic with occasional dropped lanes, flushes and clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) begin
                lane = ($urandom_range(5) == 0) ? int'($urandom_range(COLS - 1)) : -1;
                launch_row(0, {$urandom, $urandom, $urandom, $urandom}, lane);
            end
            step(($urandom_range(3) != 0), ($urandom_range(59) == 0), ($urandom_range(19) == 0));
        end
        run(10, 1'b1);

        // Asynchronous reset mid-tile discards buffered and in-flight rows.
        for (int k = 0; k < 3; k++) launch_row(k, mk_row(1300 + 16 * k), -1);
        run(6, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        clear_sched();
        mq.delete(); m_idx = 0; m_ovf = 0; m_skew = 0;
        chk("rst_valid", RW'(out_valid), RW'(1'b0));
        chk("rst_data", out_data, '0);
        run(10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_drain_deskew.md
Name: psum_drain_deskew

Overview:
- South-edge collector for the weight-stationary systolic array.
- Captures the skewed psum_out stream from the bottom PE of each column and re-aligns the lanes so that column c no longer lags column 0 by c cycles.
- Buffers aligned rows in a small FIFO and hands them to the output writer over a valid/ready handshake.
- Emits backpressure hints and error flags to the array controller.

Parameters:
- COLS, 8, number of array columns (lanes).
- PSUM_W, 32, partial-sum width per lane.
- DEPTH, 4, FIFO depth in aligned rows; power of 2, minimum 2.
- ROWS, 8, rows per output tile; sets out_row_idx wrap and out_last.
- AF_MARGIN, 1, almost_full asserts when occupancy >= DEPTH-AF_MARGIN.
- QSHIFT, 8, right-shift amount used only when DRAIN_QUANT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- col_valid_in  in  COLS  per-lane valid from the bottom PE row; skewed, lane c lags lane 0 by c cycles
- col_psum_in  in  COLS*PSUM_W  per-lane psum; lane c occupies bits [c*PSUM_W +: PSUM_W]
- flush  in  1  synchronous flush of the pipeline and FIFO
- clear_err  in  1  synchronous clear of the sticky flags
- out_valid  out  1  aligned row available
- out_ready  in  1  consumer accepts the row
- out_data  out  COLS*PSUM_W  aligned row, same lane packing as col_psum_in
- out_row_idx  out  clog2(ROWS)  index of the row currently presented
- out_last  out  1  high when out_row_idx == ROWS-1
- almost_full  out  1  occupancy >= DEPTH-AF_MARGIN
- overflow  out  1  sticky: a row was dropped because the FIFO was full
- skew_err  out  1  sticky: an aligned slot had partial lane valids

Behaviour:
- Reset (async) clears:
  - All delay registers (data and valid) to 0.
  - FIFO pointers and occupancy to 0.
  - out_row_idx to 0.
  - overflow and skew_err to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_last=0 (ROWS>1), almost_full=0.
  - Reset mid-tile discards everything in flight.
- Deskew:
  - Lane c passes through COLS-1-c registers, capturing valid and data every cycle (no enable).
  - Lane COLS-1 has zero delay.
  - Aligned slot = lane outputs at the delay-line tail in the same cycle.
- Push rules:
  - Aligned slot with all lanes valid: push request.
  - Slot with some but not all lanes valid: the row is dropped and skew_err is set.
  - No lanes valid: idle.
- FIFO:
  - Push is registered.
  - out_valid = occupancy != 0.
  - out_data is driven from the head entry and is stable while out_valid && !out_ready.
  - Pop occurs on out_valid && out_ready.
- Latency: with the FIFO empty and out_ready=1, lane 0 valid at cycle T gives out_valid=1 in cycle T+COLS. Throughput is one row per cycle.
- Full and empty boundaries:
  - Full, push, no pop: the row is dropped, overflow is set, and the FIFO is unchanged.
  - Full, push and pop in the same cycle: both succeed and occupancy stays at DEPTH.
  - Empty, push: the pop path is not combinational from the push; out_valid rises the next cycle.
- Pointers wrap modulo DEPTH.
- out_row_idx:
  - Increments on each pop and wraps from ROWS-1 to 0.
  - out_last = out_valid && out_row_idx == ROWS-1.
- flush:
  - Next edge clears the delay lines, FIFO and out_row_idx.
  - Sticky flags are kept.
  - flush has priority over a simultaneous push or pop.
- clear_err clears the sticky flags. If clear_err coincides with a new error event, the error wins and the flag stays 1.
- Arithmetic: pass-through, no width change.

Optional Feature:
- DRAIN_QUANT_EN defined:
  - Each lane is quantised on the FIFO write path as min(psum >> QSHIFT, 255).
  - The result is zero-extended to PSUM_W.
  - Latency is unchanged.
- DRAIN_QUANT_EN undefined: lanes are stored unmodified.

Test Plan:
- COLS=4: lane c valid in cycle 10+c with psum=100+c, out_ready=1 -> out_valid in cycle 14 only, with out_data lanes {103,102,101,100} (lane 3 in the MSBs), out_row_idx=0.
- 8 back-to-back skewed rows, ROWS=8, out_ready=1 -> 8 consecutive pops, idx 0..7, out_last on the 8th only, idx returns to 0.
- DEPTH=4, out_ready=0, 5 rows pushed -> occupancy 4, almost_full=1 from occupancy 3, overflow=1, the 5th row is lost, and the first 4 drain in order once out_ready=1.
- Full FIFO with out_ready=1 during a push -> no overflow, occupancy stays 4, order preserved.
- Lane 2 valid suppressed for one row -> skew_err=1, no push; clear_err -> 0; a subsequent good row is accepted.
- flush asserted while 3 rows are buffered and a row is mid-deskew -> out_valid=0 the next cycle, idx=0, nothing from that row emerges, overflow unchanged. With DRAIN_QUANT_EN and QSHIFT=8, psum 0x1234 gives 0x12 and psum 0x40000 gives 255.
